// File: rtl/rv32_mdu_if.sv
// Request/result handshake between the issue stage, the RV32M multiply/divide unit
// and write-back.
interface rv32_mdu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_wr;

  modport master (
    output in_valid, funct3, src1, src2, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, rd_out, reg_wr
  );

  modport slave (
    input  in_valid, funct3, src1, src2, rd_in, flush, out_ready,
    output in_ready, out_valid, result, rd_out, reg_wr
  );
endinterface

// File: rtl/rv32_mdu.sv
// Iterative RV32M unit: 32-step shift-add multiply and restoring divide on operand
// magnitudes, with single-edge completion for divide-by-zero and signed overflow.
module rv32_mdu #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       rst_n,
  rv32_mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT           state;
  logic [4:0]      count;
  logic [2:0]      opCode;
  logic            negRes;
  logic [XLEN-1:0] mcand, hi, lo;
  logic [XLEN-1:0] resultQ;
  logic [4:0]      rdQ;
  logic            inReadyQ, outValidQ, regWrQ;

  logic            accept, signA, signB, divZero, divOvf;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   sumMul, shiftDiv, diffDiv;
  logic [XLEN-1:0] nextHi, nextLo, divVal, finalRes;
  logic [2*XLEN-1:0] prod, prodSigned;

  // Operand decode on the request side: sign handling and fast-path detection.
  always_comb begin
    accept  = bus.in_valid && inReadyQ && !bus.flush;
    signA   = bus.src1[XLEN-1] && (bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    signB   = bus.src2[XLEN-1] && (bus.funct3 inside {3'd1, 3'd4, 3'd6});
    magA    = signA ? -bus.src1 : bus.src1;
    magB    = signB ? -bus.src2 : bus.src2;
    divZero = bus.funct3[2] && (bus.src2 == '0);
    divOvf  = bus.funct3[2] && !bus.funct3[0]
              && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src2 == '1);
  end

  // One iteration: hi:lo is the running product for multiply, and
  // remainder:quotient for divide (dividend bits shift out of lo's MSB).
  // NOTE: every branch assigns every output here, so no latch can be inferred.
  always_comb begin
    sumMul   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    shiftDiv = {hi, lo[XLEN-1]};
    diffDiv  = shiftDiv - {1'b0, mcand};
    if (opCode[2]) begin
      nextHi = diffDiv[XLEN] ? shiftDiv[XLEN-1:0] : diffDiv[XLEN-1:0];
      nextLo = {lo[XLEN-2:0], ~diffDiv[XLEN]};
    end else begin
      nextHi = sumMul[XLEN:1];
      nextLo = {sumMul[0], lo[XLEN-1:1]};
    end
    prod       = {nextHi, nextLo};
    prodSigned = negRes ? -prod : prod;
    divVal     = opCode[1] ? nextHi : nextLo;
    if (opCode[2])
      finalRes = negRes ? -divVal : divVal;
    else
      finalRes = (opCode[1:0] == 2'b00) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
  end

  // NOTE: only control and output registers are reset; the datapath registers are
  // always loaded on accept before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      regWrQ    <= 1'b0;
      resultQ   <= '0;
      rdQ       <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      regWrQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opCode   <= bus.funct3;
          rdQ      <= bus.rd_in;
          negRes   <= (bus.funct3[2] && bus.funct3[1]) ? signA : (signA ^ signB);
          count    <= '0;
          mcand    <= magB;
          hi       <= '0;
          lo       <= magA;
          inReadyQ <= 1'b0;
          if (divZero || divOvf) begin
            state     <= DONE;
            outValidQ <= 1'b1;
            regWrQ    <= (bus.rd_in != 5'd0);
            if (divZero)
              resultQ <= bus.funct3[1] ? bus.src1 : '1;
            else
              resultQ <= bus.funct3[1] ? '0 : bus.src1;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          hi    <= nextHi;
          lo    <= nextLo;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state     <= DONE;
            outValidQ <= 1'b1;
            regWrQ    <= (rdQ != 5'd0);
            resultQ   <= finalRes;
          end
        end
        DONE: if (bus.out_ready) begin
          state     <= IDLE;
          inReadyQ  <= 1'b1;
          outValidQ <= 1'b0;
          regWrQ    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.reg_wr    = regWrQ;
  assign bus.result    = resultQ;
  assign bus.rd_out    = rdQ;
endmodule

// File: tb/tb_rv32_mdu.sv
// Directed bench for rv32_mdu: an arithmetic reference model feeds an expectation
// queue that a negedge monitor checks on every valid cycle.
module tb_rv32_mdu;
  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   acceptCyc = 0;
  bit   monOn = 1'b0;
  bit   seenValid = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] want;
    int          hold;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[18];

  rv32_mdu_if #(.XLEN(32)) bus ();
  rv32_mdu #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  // Architectural RV32M results computed with plain 64-bit/32-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    logic   ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from the accept edge (inclusive) to the first cycle out_valid is seen.
  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Monitor: every negedge, compare outputs against the head of the expectation queue.
  always @(negedge clk) begin
    if (monOn) begin
      if (bus.in_valid && bus.in_ready && !bus.flush && rst_n) acceptCyc = cyc + 1;
      if (bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          if (!seenValid) check("latency", 32'(cyc - acceptCyc + 1), 32'(expQ[0].lat));
          check("result", bus.result, expQ[0].res);
          check("rd_out", {27'd0, bus.rd_out}, {27'd0, expQ[0].rd});
          check("reg_wr", {31'd0, bus.reg_wr}, {31'd0, expQ[0].rd != 5'd0});
          if (bus.out_ready) void'(expQ.pop_front());
        end
        seenValid = 1'b1;
      end else begin
        check("reg_wr_idle", {31'd0, bus.reg_wr}, 32'd0);
        seenValid = 1'b0;
      end
    end
  end

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.src1     = a;
    bus.src2     = b;
    bus.rd_in    = rd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    exp_t e;
    int   n = 0;
    e.res = refModel(f3, a, b);
    e.rd  = rd;
    e.lat = refLatency(f3, a, b);
    expQ.push_back(e);
    present(f3, a, b, rd);
    while (bus.out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (bus.out_valid !== 1'b1) begin
      check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
      void'(expQ.pop_front());
    end else begin
      repeat (hold) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.rd_in     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_reg_wr",    {31'd0, bus.reg_wr}, 32'd0);
    check("rst_result",    bus.result, 32'd0);
    check("rst_rd_out",    {27'd0, bus.rd_out}, 32'd0);
    rst_n = 1'b1;
    monOn = 1'b1;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 0};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 0};
    vecs[4]  = '{3'd4, 32'd5,          32'd0,         5'd4,  32'hFFFF_FFFF, 0};
    vecs[5]  = '{3'd7, 32'd5,          32'd0,         5'd6,  32'h0000_0005, 0};
    vecs[6]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 0};
    vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 0};
    vecs[8]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 0};
    vecs[9]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 0};
    vecs[10] = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        0};
    vecs[11] = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         0};
    vecs[12] = '{3'd5, 32'hFFFF_FFFF,  32'h10,        5'd31, 32'h0FFF_FFFF, 10};
    vecs[13] = '{3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        2};
    vecs[14] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd13, 32'h4000_0000, 0};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFD, 5'd14, 32'd1,         0};
    vecs[16] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         0};
    vecs[17] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd0,  32'hFFFF_FFF9, 1};

    foreach (vecs[i]) begin
      check($sformatf("model_vec%0d", i), refModel(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].want);
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].hold);
    end

    // Flush at counter=10: back to IDLE on the next edge, result discarded.
    present(3'd0, 32'd9, 32'd9, 5'd20);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Flush with a simultaneous request in IDLE: request is not accepted.
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_blocks_accept", {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Reset mid-BUSY: no out_valid afterwards.
    present(3'd5, 32'd1000, 32'd3, 5'd21);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_busy_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Reset in DONE: result pulled down on the reset edge.
    begin
      exp_t e;
      e.res = refModel(3'd4, 32'd5, 32'd0);
      e.rd  = 5'd3;
      e.lat = refLatency(3'd4, 32'd5, 32'd0);
      expQ.push_back(e);
    end
    present(3'd4, 32'd5, 32'd0, 5'd3);
    check("done_before_rst", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_done_reg_wr",    {31'd0, bus.reg_wr}, 32'd0);
    check("rst_done_result",    bus.result, 32'd0);
    check("rst_done_rd_out",    {27'd0, bus.rd_out}, 32'd0);
    rst_n = 1'b1;
    void'(expQ.pop_front());
    @(posedge clk); #1;
    check("rst_done_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Normal operation resumes after the aborts.
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd17, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/rv32_mdu.md
RV32_MDU -- requirements
Module: rv32_mdu

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  unit can accept a request.
REQ-006 Port: funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port: src1  input  32  rs1 operand, taken from GPR read port A.
REQ-008 Port: src2  input  32  rs2 operand, taken from GPR read port B.
REQ-009 Port: rd_in  input  5  destination register index.
REQ-010 Port: flush  input  1  kill the in-flight operation.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  write-back stage consumes the result.
REQ-013 Port: result  output  32  value for GPR busW.
REQ-014 Port: rd_out  output  5  GPR write index (Rw).
REQ-015 Port: reg_wr  output  1  GPR write enable; equals out_valid AND (rd_out != 0).

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on an edge where in_valid=1, in_ready=1 and flush=0; funct3, src1, src2 and rd_in SHALL be latched on that edge.
REQ-018 Normal path: the accept edge SHALL move IDLE->BUSY and clear a 5-bit counter; each BUSY edge SHALL perform one iteration (multiply: shift-add, one multiplier bit per edge; divide: restoring, one quotient bit per edge); the edge with counter=31 SHALL move BUSY->DONE.
REQ-019 out_valid SHALL therefore be observed after the 32nd rising edge following the accept edge.
REQ-020 Fast path: divide/remainder with src2=0, and signed overflow (DIV/REM, src1=0x80000000, src2=0xFFFFFFFF), SHALL go IDLE->DONE on the accept edge, so out_valid is observed after 1 edge.
REQ-021 Multiply SHALL form the full 64-bit product: MUL returns bits[31:0]; MULH treats both operands as signed; MULHSU treats src1 as signed and src2 as unsigned; MULHU treats both as unsigned; MULH, MULHSU and MULHU return bits[63:32].
REQ-022 Signed operations SHALL iterate on magnitudes and negate at the end: the quotient is negative iff the operand signs differ (nonzero divisor), and the remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL produce: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = src1.
REQ-024 Signed overflow SHALL produce: DIV = 0x80000000; REM = 0.
REQ-025 In DONE, result, rd_out and reg_wr SHALL hold stable while out_ready=0.
REQ-026 In DONE, an edge with out_ready=1 SHALL move to IDLE; a new request is not accepted on that same edge.
REQ-027 flush=1 SHALL force IDLE on the next edge from any state, overriding all other conditions: it discards any BUSY/DONE result, and a simultaneous in_valid is not accepted.
REQ-028 A result with rd_out=0 SHALL still complete the handshake normally, with reg_wr=0.

Reset
REQ-029 An edge with rst_n=0 SHALL set: state to IDLE, counter to 0, out_valid to 0, reg_wr to 0, result to 0x00000000 and rd_out to 0; rst_n SHALL take priority over flush and in_valid.
REQ-030 Asserting rst_n=0 mid-BUSY or in DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the cycle after rst_n returns high.

Verification
REQ-031 MUL, src1=7, src2=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out 5, reg_wr 1, out_valid observed 32 edges after accept.
REQ-032 src1=src2=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-033 DIV 5/0 -> 0xFFFFFFFF and REMU 5%0 -> 0x00000005, each with out_valid observed 1 edge after accept.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000; both on the fast path.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> result stable throughout; flush at BUSY counter=10 -> IDLE next edge with no out_valid; reset in DONE -> out_valid 0 next edge; rd_in=0 -> reg_wr stays 0.
